memctrl_port_arbiter: RTL and testbench

- Shares the single SRAM-side port of the memory controller between two host requesters (REQ0: CPU, REQ1: DMA) using round-robin arbitration.
- Sequences each access with the controller's strobe protocol:
  - one strobe cycle with CE=1, CSB=0 and WEB/OEB active;
  - then a recovery phase with strobes idle.
- Returns read data to the granted requester.
- Grants no new accesses while the BIST/BISR engine owns the memory (BIST_BUSY high).

---
 rtl/memctrl_port_arbiter_if.sv | 42 ++++
 rtl/memctrl_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_memctrl_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memctrl_port_arbiter_if.sv
// Host and SRAM-side bundle of the memory-controller port arbiter.
// The slave modport is the arbiter; the master modport is the host/memory side.
interface memctrl_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          bist_busy;
  logic          busy;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_idata;
  logic          m_ce;
  logic          m_csb;
  logic          m_web;
  logic          m_oeb;
  logic [DW-1:0] m_odata;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bist_busy, m_odata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy,
    input  m_addr, m_idata, m_ce, m_csb, m_web, m_oeb
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bist_busy, m_odata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy,
    output m_addr, m_idata, m_ce, m_csb, m_web, m_oeb
  );
endinterface

// File: rtl/memctrl_port_arbiter.sv
// Round-robin arbiter sharing one SRAM port between CPU (req0) and DMA (req1),
// driving a single strobe cycle per access followed by RD_LAT recovery cycles.
module memctrl_port_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  memctrl_port_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RECOV  = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [1:0] CNT_LOAD = 2'(RD_LAT - 1);

  state_t        state_r;
  state_t        next_s;
  logic [1:0]    cnt_r;
  logic          last_r;
  logic          sel_r;
  logic          we_r;
  logic          grant_s;
  logic          win_s;
  logic          win_we_s;
  logic [AW-1:0] win_addr_s;
  logic [DW-1:0] win_wdata_s;
  logic          read_done_s;

  logic          gnt0_r;
  logic          gnt1_r;
  logic          rvalid0_r;
  logic          rvalid1_r;
  logic [DW-1:0] rdata0_r;
  logic [DW-1:0] rdata1_r;
  logic          busy_r;
  logic [AW-1:0] m_addr_r;
  logic [DW-1:0] m_idata_r;
  logic          m_ce_r;
  logic          m_csb_r;
  logic          m_web_r;
  logic          m_oeb_r;

  // Next-state and arbitration decision; BIST ownership only blocks new grants from IDLE
  always_comb begin
    next_s  = state_r;
    grant_s = 1'b0;
    win_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!bus.bist_busy && (bus.req0 || bus.req1)) begin
          grant_s = 1'b1;
          if (bus.req0 && bus.req1) begin
            win_s = ~last_r;
          end else begin
            win_s = bus.req1;
          end
          next_s = ACCESS;
        end else begin
          next_s = IDLE;
        end
      end
      ACCESS: next_s = RECOV;
      RECOV: begin
        if (cnt_r == 2'd0) begin
          next_s = RESP;
        end else begin
          next_s = RECOV;
        end
      end
      RESP:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Winner's request fields
  always_comb begin
    win_we_s    = 1'b0;
    win_addr_s  = '0;
    win_wdata_s = '0;
    if (win_s) begin
      win_we_s    = bus.we1;
      win_addr_s  = bus.addr1;
      win_wdata_s = bus.wdata1;
    end else begin
      win_we_s    = bus.we0;
      win_addr_s  = bus.addr0;
      win_wdata_s = bus.wdata0;
    end
  end

  assign read_done_s = (state_r == RECOV) && (cnt_r == 2'd0) && !we_r;

  // State, round-robin pointer, recovery counter and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= 2'd0;
      last_r    <= 1'b1;
      sel_r     <= 1'b0;
      we_r      <= 1'b0;
      gnt0_r    <= 1'b0;
      gnt1_r    <= 1'b0;
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      rdata0_r  <= '0;
      rdata1_r  <= '0;
      busy_r    <= 1'b0;
      m_addr_r  <= '0;
      m_idata_r <= '0;
      m_ce_r    <= 1'b0;
      m_csb_r   <= 1'b1;
      m_web_r   <= 1'b1;
      m_oeb_r   <= 1'b1;
    end else begin
      state_r   <= next_s;
      gnt0_r    <= grant_s && !win_s;
      gnt1_r    <= grant_s && win_s;
      m_ce_r    <= grant_s;
      m_csb_r   <= !grant_s;
      m_web_r   <= !(grant_s && win_we_s);
      m_oeb_r   <= !(grant_s && !win_we_s);
      busy_r    <= (next_s != IDLE);
      rvalid0_r <= read_done_s && !sel_r;
      rvalid1_r <= read_done_s && sel_r;
      if (grant_s) begin
        sel_r    <= win_s;
        last_r   <= win_s;
        we_r     <= win_we_s;
        m_addr_r <= win_addr_s;
        if (win_we_s) begin
          m_idata_r <= win_wdata_s;
        end
      end
      // Counter is loaded during the strobe so RECOV lasts exactly RD_LAT cycles
      if (state_r == ACCESS) begin
        cnt_r <= CNT_LOAD;
      end else if ((state_r == RECOV) && (cnt_r != 2'd0)) begin
        cnt_r <= cnt_r - 2'd1;
      end
      if (read_done_s && !sel_r) begin
        rdata0_r <= bus.m_odata;
      end
      if (read_done_s && sel_r) begin
        rdata1_r <= bus.m_odata;
      end
    end
  end

  assign bus.gnt0    = gnt0_r;
  assign bus.gnt1    = gnt1_r;
  assign bus.rvalid0 = rvalid0_r;
  assign bus.rvalid1 = rvalid1_r;
  assign bus.rdata0  = rdata0_r;
  assign bus.rdata1  = rdata1_r;
  assign bus.busy    = busy_r;
  assign bus.m_addr  = m_addr_r;
  assign bus.m_idata = m_idata_r;
  assign bus.m_ce    = m_ce_r;
  assign bus.m_csb   = m_csb_r;
  assign bus.m_web   = m_web_r;
  assign bus.m_oeb   = m_oeb_r;
endmodule

// File: tb/tb_memctrl_port_arbiter.sv
// Bench for memctrl_port_arbiter: a cycle-timeline reference model checks an RD_LAT=1
// instance under directed and random traffic; an RD_LAT=3 instance covers reset mid-read.
module tb_memctrl_port_arbiter;
  localparam int LAT_A = 1;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   n_checks;
  int   n_pass;
  int   cyc;

  memctrl_port_arbiter_if #(.AW(16), .DW(8)) ia ();
  memctrl_port_arbiter_if #(.AW(16), .DW(8)) ib ();

  memctrl_port_arbiter #(.AW(16), .DW(8), .RD_LAT(LAT_A)) dut_a (.clk(clk), .rst(rst_a), .bus(ia));
  memctrl_port_arbiter #(.AW(16), .DW(8), .RD_LAT(3))     dut_b (.clk(clk), .rst(rst_b), .bus(ib));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents are a fixed function of the address
  function automatic logic [7:0] memf(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'h18;
  endfunction

  logic [7:0] pipe_a;
  logic [7:0] pipe_b [3];

  // SRAM read pipelines: data appears RD_LAT cycles after the read strobe, junk otherwise
  always @(posedge clk) begin
    pipe_a    <= (ia.m_ce && !ia.m_csb && !ia.m_oeb) ? memf(ia.m_addr) : 8'hEE;
    pipe_b[0] <= (ib.m_ce && !ib.m_csb && !ib.m_oeb) ? memf(ib.m_addr) : 8'hEE;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign ia.m_odata = pipe_a;
  assign ib.m_odata = pipe_b[2];

  // Stimulus variables for instance A
  logic        r0, r1, w0, w1, bist;
  logic [15:0] a0, a1;
  logic [7:0]  d0, d1;

  // Reference model: timeline of the current transaction
  int          acc_cyc, free_cyc;
  logic        m_last, m_win, m_we;
  logic [15:0] e_addr;
  logic [7:0]  e_idata, e_rd0, e_rd1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic sync_check();
    logic acc, rv;
    @(negedge clk);
    cyc++;
    acc = (cyc == acc_cyc);
    rv  = (cyc == acc_cyc + LAT_A + 1) && !m_we;
    if (rv && m_win)  e_rd1 = memf(e_addr);
    if (rv && !m_win) e_rd0 = memf(e_addr);
    chk("gnt0",    16'(ia.gnt0),    16'(acc && !m_win));
    chk("gnt1",    16'(ia.gnt1),    16'(acc && m_win));
    chk("m_ce",    16'(ia.m_ce),    16'(acc));
    chk("m_csb",   16'(ia.m_csb),   16'(!acc));
    chk("m_web",   16'(ia.m_web),   16'(!(acc && m_we)));
    chk("m_oeb",   16'(ia.m_oeb),   16'(!(acc && !m_we)));
    chk("m_addr",  ia.m_addr,       e_addr);
    chk("m_idata", 16'(ia.m_idata), 16'(e_idata));
    chk("rvalid0", 16'(ia.rvalid0), 16'(rv && !m_win));
    chk("rvalid1", 16'(ia.rvalid1), 16'(rv && m_win));
    chk("rdata0",  16'(ia.rdata0),  16'(e_rd0));
    chk("rdata1",  16'(ia.rdata1),  16'(e_rd1));
    chk("busy",    16'(ia.busy),    16'((cyc >= acc_cyc) && (cyc < free_cyc)));
  endtask

  task automatic decide_a();
    ia.req0 = r0; ia.we0 = w0; ia.addr0 = a0; ia.wdata0 = d0;
    ia.req1 = r1; ia.we1 = w1; ia.addr1 = a1; ia.wdata1 = d1;
    ia.bist_busy = bist;
    if (rst_a) begin
      acc_cyc = -100; free_cyc = cyc + 1; m_last = 1'b1; m_win = 1'b0; m_we = 1'b0;
      e_addr = 16'h0000; e_idata = 8'h00; e_rd0 = 8'h00; e_rd1 = 8'h00;
    end else if (cyc >= free_cyc && !bist && (r0 || r1)) begin
      m_win    = (r0 && r1) ? !m_last : r1;
      m_last   = m_win;
      m_we     = m_win ? w1 : w0;
      e_addr   = m_win ? a1 : a0;
      if (m_we) e_idata = m_win ? d1 : d0;
      acc_cyc  = cyc + 1;
      free_cyc = cyc + 1 + LAT_A + 2;
    end
  endtask

  task automatic set_idle();
    r0 = 1'b0; r1 = 1'b0; w0 = 1'b0; w1 = 1'b0; bist = 1'b0; rst_a = 1'b0;
    a0 = 16'h0000; a1 = 16'h0000; d0 = 8'h00; d1 = 8'h00;
  endtask

  task automatic randomize_inputs();
    r0 = 1'($urandom); r1 = 1'($urandom); w0 = 1'($urandom); w1 = 1'($urandom);
    a0 = 16'($urandom); a1 = 16'($urandom); d0 = 8'($urandom); d1 = 8'($urandom);
    bist = 1'($urandom);
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) begin
      sync_check();
      decide_a();
    end
  endtask

  initial begin
    int          gq[$];
    int          gc[$];
    int          rv0_cnt, g1_cnt;
    n_checks = 0; n_pass = 0; cyc = 0;
    set_idle();
    ib.req0 = 1'b0; ib.req1 = 1'b0; ib.we0 = 1'b0; ib.we1 = 1'b0;
    ib.addr0 = 16'h0000; ib.addr1 = 16'h0000; ib.wdata0 = 8'h00; ib.wdata1 = 8'h00;
    ib.bist_busy = 1'b0;

    // Test 1: reset held with random inputs
    rst_a = 1'b1; rst_b = 1'b1;
    randomize_inputs();
    decide_a();
    for (int i = 0; i < 3; i++) begin
      sync_check();
      if (i < 2) begin
        randomize_inputs();
      end else begin
        set_idle();
        rst_b = 1'b0;
      end
      decide_a();
    end

    // Test 2: REQ0 write
    sync_check();
    r0 = 1'b1; w0 = 1'b1; a0 = 16'hF658; d0 = 8'hA5;
    decide_a();
    sync_check();
    chk("t2_gnt0", 16'(ia.gnt0), 16'h0001);
    chk("t2_web",  16'(ia.m_web), 16'h0000);
    chk("t2_addr", ia.m_addr, 16'hF658);
    chk("t2_data", 16'(ia.m_idata), 16'h00A5);
    r0 = 1'b0;
    decide_a();
    idle_a(4);

    // Test 3: REQ1 read of a location holding 8'h3C
    sync_check();
    r1 = 1'b1; w1 = 1'b0; a1 = 16'hECC8;
    decide_a();
    sync_check();
    chk("t3_gnt1", 16'(ia.gnt1), 16'h0001);
    chk("t3_oeb",  16'(ia.m_oeb), 16'h0000);
    r1 = 1'b0;
    decide_a();
    idle_a(1);
    sync_check();
    chk("t3_rvalid1", 16'(ia.rvalid1), 16'h0001);
    chk("t3_rdata1",  16'(ia.rdata1), 16'h003C);
    decide_a();
    idle_a(2);

    // Test 4: both requesters held; grants alternate starting with REQ0
    sync_check();
    r0 = 1'b1; w0 = 1'b1; a0 = 16'h1000; d0 = 8'h11;
    r1 = 1'b1; w1 = 1'b0; a1 = 16'h2000;
    decide_a();
    for (int i = 0; i < 14; i++) begin
      sync_check();
      if (ia.gnt0) begin gq.push_back(0); gc.push_back(cyc); end
      if (ia.gnt1) begin gq.push_back(1); gc.push_back(cyc); end
      decide_a();
    end
    chk("t4_ngrants", 16'(gq.size() >= 4), 16'h0001);
    if (gq.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t4_order", 16'(gq[i]), 16'(i % 2));
        if (i > 0) chk("t4_spacing", 16'(gc[i] - gc[i-1]), 16'd4);
      end
    end
    sync_check();
    set_idle();
    decide_a();
    idle_a(6);

    // Test 5: BIST raised during the strobe of a REQ0 read with REQ1 pending
    sync_check();
    r0 = 1'b1; w0 = 1'b0; a0 = 16'h0A0B;
    decide_a();
    sync_check();
    chk("t5_gnt0", 16'(ia.gnt0), 16'h0001);
    r0 = 1'b0; r1 = 1'b1; w1 = 1'b0; a1 = 16'h0C0D; bist = 1'b1;
    decide_a();
    rv0_cnt = 0; g1_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      sync_check();
      if (ia.rvalid0) rv0_cnt++;
      if (ia.gnt1) g1_cnt++;
      decide_a();
    end
    chk("t5_rvalid0_count", 16'(rv0_cnt), 16'd1);
    chk("t5_gnt1_blocked", 16'(g1_cnt), 16'd0);
    sync_check();
    bist = 1'b0;
    decide_a();
    sync_check();
    chk("t5_gnt1", 16'(ia.gnt1), 16'h0001);
    r1 = 1'b0;
    decide_a();
    idle_a(4);

    // Test 6: reset during RECOV of an RD_LAT=3 read on instance B
    sync_check();
    ib.req0 = 1'b1; ib.we0 = 1'b0; ib.addr0 = 16'h1234;
    decide_a();
    sync_check();
    chk("t6_gnt0", 16'(ib.gnt0), 16'h0001);
    chk("t6_oeb",  16'(ib.m_oeb), 16'h0000);
    ib.req0 = 1'b0;
    decide_a();
    sync_check();
    chk("t6_busy_recov", 16'(ib.busy), 16'h0001);
    rst_b = 1'b1;
    decide_a();
    sync_check();
    chk("t6_rst_gnt", 16'({ib.gnt0, ib.gnt1}), 16'h0000);
    chk("t6_rst_rvalid", 16'({ib.rvalid0, ib.rvalid1}), 16'h0000);
    chk("t6_rst_busy", 16'(ib.busy), 16'h0000);
    chk("t6_rst_addr", ib.m_addr, 16'h0000);
    chk("t6_rst_strobes", 16'({ib.m_ce, ib.m_csb, ib.m_web, ib.m_oeb}), 16'h0007);
    chk("t6_rst_rdata0", 16'(ib.rdata0), 16'h0000);
    rst_b = 1'b0;
    ib.req1 = 1'b1; ib.we1 = 1'b0; ib.addr1 = 16'h4321;
    decide_a();
    sync_check();
    chk("t6_gnt1", 16'(ib.gnt1), 16'h0001);
    chk("t6_no_gnt0", 16'(ib.gnt0), 16'h0000);
    ib.req1 = 1'b0;
    decide_a();
    for (int n = 0; n < 4; n++) begin
      sync_check();
      chk("t6_no_rvalid0", 16'(ib.rvalid0), 16'h0000);
      chk("t6_rvalid1", 16'(ib.rvalid1), 16'(n == 3));
      if (n == 3) chk("t6_rdata1", 16'(ib.rdata1), 16'(memf(16'h4321)));
      decide_a();
    end

    // Random traffic: requesters hold until granted, may withdraw; BIST and reset toggle
    for (int i = 0; i < 3000; i++) begin
      sync_check();
      rst_a = ($urandom_range(199) == 0);
      if (r0 && ia.gnt0) begin
        if ($urandom_range(1) == 0) r0 = 1'b0;
        else begin w0 = 1'($urandom); a0 = 16'($urandom); d0 = 8'($urandom); end
      end else if (r0) begin
        if ($urandom_range(15) == 0) r0 = 1'b0;
      end else if ($urandom_range(3) == 0) begin
        r0 = 1'b1; w0 = 1'($urandom); a0 = 16'($urandom); d0 = 8'($urandom);
      end
      if (r1 && ia.gnt1) begin
        if ($urandom_range(1) == 0) r1 = 1'b0;
        else begin w1 = 1'($urandom); a1 = 16'($urandom); d1 = 8'($urandom); end
      end else if (r1) begin
        if ($urandom_range(15) == 0) r1 = 1'b0;
      end else if ($urandom_range(3) == 0) begin
        r1 = 1'b1; w1 = 1'($urandom); a1 = 16'($urandom); d1 = 8'($urandom);
      end
      if ($urandom_range(7) == 0) bist = ~bist;
      decide_a();
    end
    idle_a(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
